hazard_ctrl: RTL



---
 rtl/hazard_ctrl_if.sv | 51 +++++
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: signal bundle between the ID/EX pipeline control and hazard_ctrl.
//   master: pipeline side, drives ID/EX register contents and gets stall/flush/forward controls.
//   slave : hazard_ctrl side.
//   id_*        source registers and read enables of the ID instruction
//   ex_*        fields held in the ID/EX register, plus the taken-redirect indication
//   stall_*     hold PC, IF/ID, ID/EX
//   flush_*     load a bubble into IF/ID, ID/EX
//   mem_bubble  EX/MEM captures a bubble this edge
//   fwd_a/b     EX operand select: 00 regfile, 10 MEM result, 01 WB result
//   mc_done     last EX cycle of a multi-cycle instruction
//   stall_cycles, flush_events  saturating performance counters
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_is_load;
    logic             ex_mc_start;
    logic             ex_redirect;
    logic             stall_pc;
    logic             stall_if_id;
    logic             stall_id_ex;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             mem_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mc_done;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_reg_write, ex_is_load, ex_mc_start, ex_redirect,
        input  stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, mem_bubble,
               fwd_a, fwd_b, mc_done, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_reg_write, ex_is_load, ex_mc_start, ex_redirect,
        output stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, mem_bubble,
               fwd_a, fwd_b, mc_done, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
//   Generates PC/IF/ID/EX stalls and flushes (redirect > multi-cycle > load-use),
//   EX operand forwarding selects from a shadow copy of the MEM/WB destinations,
//   a multi-cycle (mul/div) stall FSM and saturating stall/flush counters.
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-high reset
//   hz_io  hazard_ctrl_if slave modport (all data/control signals)
module hazard_ctrl #(
    parameter int unsigned MC_LAT = 4,   // cycles a multi-cycle op occupies EX, 2..255
    parameter int unsigned CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz_io
);
    typedef enum logic {StIdle, StBusy} mc_state_e;

    localparam logic [7:0] McInit = 8'(MC_LAT - 2);

    mc_state_e        state_q;
    logic [7:0]       mc_cnt_q;
    logic             mc_done_q;
    logic [4:0]       mem_rd_q, wb_rd_q;
    logic             mem_we_q, wb_we_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mc_busy, mc_stall, load_use;

    assign mc_busy  = (state_q == StBusy);
    assign mc_stall = (hz_io.ex_mc_start && !mc_busy) || (mc_busy && (mc_cnt_q != 8'd0));
    assign load_use = hz_io.ex_is_load && hz_io.ex_reg_write && (hz_io.ex_rd != 5'd0) &&
                      ((hz_io.id_use_rs1 && (hz_io.id_rs1 == hz_io.ex_rd)) ||
                       (hz_io.id_use_rs2 && (hz_io.id_rs2 == hz_io.ex_rd)));

    always_comb begin
        hz_io.stall_pc    = 1'b0;
        hz_io.stall_if_id = 1'b0;
        hz_io.stall_id_ex = 1'b0;
        hz_io.flush_if_id = 1'b0;
        hz_io.flush_id_ex = 1'b0;
        hz_io.mem_bubble  = 1'b0;
        if (hz_io.ex_redirect) begin
            hz_io.flush_if_id = 1'b1;
            hz_io.flush_id_ex = 1'b1;
        end else if (mc_stall) begin
            hz_io.stall_pc    = 1'b1;
            hz_io.stall_if_id = 1'b1;
            hz_io.stall_id_ex = 1'b1;
            hz_io.mem_bubble  = 1'b1;
        end else if (load_use) begin
            // The load proceeds to MEM; the consumer waits one cycle behind a bubble.
            hz_io.stall_pc    = 1'b1;
            hz_io.stall_if_id = 1'b1;
            hz_io.flush_id_ex = 1'b1;
        end
    end

    // MEM beats WB; x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (mem_we_q && (mem_rd_q != 5'd0) && (mem_rd_q == rs)) return 2'b10;
        if (wb_we_q && (wb_rd_q != 5'd0) && (wb_rd_q == rs))    return 2'b01;
        return 2'b00;
    endfunction

    assign hz_io.fwd_a        = fwd_sel(hz_io.ex_rs1);
    assign hz_io.fwd_b        = fwd_sel(hz_io.ex_rs2);
    assign hz_io.mc_done      = mc_done_q;
    assign hz_io.stall_cycles = stall_cnt_q;
    assign hz_io.flush_events = flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz_io.stall_pc && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
        if (hz_io.flush_if_id && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // Multi-cycle FSM; mc_done_q is precomputed so it is high exactly while BUSY with count 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            mc_cnt_q  <= 8'd0;
            mc_done_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (hz_io.ex_mc_start && !hz_io.ex_redirect) begin
                        state_q   <= StBusy;
                        mc_cnt_q  <= McInit;
                        mc_done_q <= (McInit == 8'd0);
                    end
                end
                StBusy: begin
                    if (mc_cnt_q != 8'd0) begin
                        mc_cnt_q  <= mc_cnt_q - 8'd1;
                        mc_done_q <= (mc_cnt_q == 8'd1);
                    end else begin
                        state_q   <= StIdle;
                        mc_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    mc_done_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rd_q    <= 5'd0;
            mem_we_q    <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_we_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            wb_rd_q     <= mem_rd_q;
            wb_we_q     <= mem_we_q;
            mem_rd_q    <= hz_io.mem_bubble ? 5'd0 : hz_io.ex_rd;
            mem_we_q    <= hz_io.mem_bubble ? 1'b0 : hz_io.ex_reg_write;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule
